// File: rtl/csa_product_resolver.sv
// Serial carry-propagate resolver: adds a carry-save (pp, carry) pair CHUNK bits per cycle.
// Define CSA_RESOLVE_FAST_EN to resolve the full width in a single ADD cycle instead.
module csa_product_resolver #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   pp_in,
   input  logic [2*WIDTH-1:0]   carry_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 ovf,
   output logic                 busy
);

   localparam int PW     = 2 * WIDTH;
   localparam int NCHUNK = PW / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     op_pp_q, op_pp_d;
   logic [PW-1:0]     op_carry_q, op_carry_d;
   logic [PW-1:0]     result_q, result_d;
   logic              ovf_q, ovf_d;

`ifdef CSA_RESOLVE_FAST_EN
   logic [PW:0]       full_sum;

   assign full_sum = {1'b0, op_pp_q} + {1'b0, op_carry_q};
`else
   logic              cbit_q, cbit_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CHUNK:0]    chunk_sum;

   // Only the low chunk of each operand is ever added; the operands shift down to feed it.
   assign chunk_sum = {1'b0, op_pp_q[CHUNK-1:0]} + {1'b0, op_carry_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cbit_q};
`endif

   always_comb begin
      // NOTE: every variable gets a hold-value default before the case, so no path infers a latch.
      state_d    = state_q;
      op_pp_d    = op_pp_q;
      op_carry_d = op_carry_q;
      result_d   = result_q;
      ovf_d      = ovf_q;
`ifndef CSA_RESOLVE_FAST_EN
      cbit_d     = cbit_q;
      cnt_d      = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_pp_d    = pp_in;
               op_carry_d = carry_in;
               result_d   = '0;
               ovf_d      = 1'b0;
`ifndef CSA_RESOLVE_FAST_EN
               cbit_d     = 1'b0;
               cnt_d      = '0;
`endif
               state_d    = ADD;
            end
         end
         ADD: begin
`ifdef CSA_RESOLVE_FAST_EN
            result_d = full_sum[PW-1:0];
            ovf_d    = full_sum[PW];
            state_d  = DONE;
`else
            result_d   = {chunk_sum[CHUNK-1:0], result_q[PW-1:CHUNK]};
            op_pp_d    = op_pp_q >> CHUNK;
            op_carry_d = op_carry_q >> CHUNK;
            cbit_d     = chunk_sum[CHUNK];
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CW'(NCHUNK - 1)) begin
               ovf_d   = chunk_sum[CHUNK];
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_pp_q    <= '0;
         op_carry_q <= '0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
`ifndef CSA_RESOLVE_FAST_EN
         cbit_q     <= 1'b0;
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_pp_q    <= op_pp_d;
         op_carry_q <= op_carry_d;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
`ifndef CSA_RESOLVE_FAST_EN
         cbit_q     <= cbit_d;
         cnt_q      <= cnt_d;
`endif
      end
   end

   // Handshake flags come straight from the state register, never from in_valid/out_ready.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == ADD);
   assign product   = result_q;
   assign ovf       = ovf_q;

endmodule
